// File: rtl/x_vector_mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among NUM_PORTS x-vector requesters.
// Define ARB_PERF_COUNTERS_EN to add the per-port issue and stall-cycle performance counters.
module x_vector_mem_arbiter #(
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned LOG2_NUM_PORTS  = 2,
   parameter int unsigned REQ_FIFO_DEPTH  = 32,
   parameter int unsigned MAX_OUTSTANDING = 512
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_PORTS-1:0]      req_mem,
   input  logic [48*NUM_PORTS-1:0]   req_mem_addr,
   output logic [NUM_PORTS-1:0]      req_afull,
   output logic                      mc_req_ld,
   output logic [47:0]               mc_req_addr,
   output logic [LOG2_NUM_PORTS-1:0] mc_req_tag,
   input  logic                      mc_req_stall,
   input  logic                      mc_rsp_push,
   input  logic [LOG2_NUM_PORTS-1:0] mc_rsp_tag,
   input  logic [63:0]               mc_rsp_data,
   output logic [NUM_PORTS-1:0]      rsp_mem_push,
   output logic [63:0]               rsp_mem_q,
`ifdef ARB_PERF_COUNTERS_EN
   output logic [32*NUM_PORTS-1:0]   perf_issue_cnt,
   output logic [31:0]               perf_stall_cnt,
`endif
   output logic [2:0]                err_status,
   output logic                      idle
);

   localparam int unsigned PtrW = $clog2(REQ_FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CntW-1:0] FullCnt  = CntW'(REQ_FIFO_DEPTH);
   localparam logic [CntW-1:0] AfullCnt = CntW'(REQ_FIFO_DEPTH - 4);
   localparam logic [OutW:0]   MaxOut   = (OutW + 1)'(MAX_OUTSTANDING);
   localparam logic [LOG2_NUM_PORTS-1:0] LastPort = LOG2_NUM_PORTS'(NUM_PORTS - 1);

   logic [47:0] fifo_mem [NUM_PORTS][REQ_FIFO_DEPTH];

   logic [NUM_PORTS-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NUM_PORTS-1:0][CntW-1:0] cnt_q, cnt_d;
   logic [NUM_PORTS-1:0][OutW-1:0] outst_q, outst_d;
   logic [NUM_PORTS-1:0]           push, pop, eligible, issue_hit, rsp_hit;

   logic [LOG2_NUM_PORTS-1:0] rr_q, rr_d;
   logic                      grant_vld;
   logic [LOG2_NUM_PORTS-1:0] grant_idx;

   logic                      mc_req_ld_q, mc_req_ld_d;
   logic [47:0]               mc_req_addr_q, mc_req_addr_d;
   logic [LOG2_NUM_PORTS-1:0] mc_req_tag_q, mc_req_tag_d;

   logic                 rsp_tag_ok;
   logic [NUM_PORTS-1:0] rsp_push_q, rsp_push_d;
   logic [63:0]          rsp_data_q, rsp_data_d;

   logic       overflow, bad_tag, unexpected;
   logic [2:0] err_q, err_d;
   logic       idle_q, idle_d;

   assign rsp_tag_ok = 32'(mc_rsp_tag) < NUM_PORTS;
   assign bad_tag    = mc_rsp_push && !rsp_tag_ok;

   // A grant registered last cycle has not reached outst_q yet, so count it against the cap.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         issue_hit[i] = mc_req_ld_q && (mc_req_tag_q == LOG2_NUM_PORTS'(i));
         rsp_hit[i]   = mc_rsp_push && rsp_tag_ok && (mc_rsp_tag == LOG2_NUM_PORTS'(i));
         eligible[i]  = (cnt_q[i] != '0) &&
                        (({1'b0, outst_q[i]} + (OutW + 1)'(issue_hit[i])) < MaxOut);
         req_afull[i] = cnt_q[i] >= AfullCnt;
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_vld && eligible[i] && (LOG2_NUM_PORTS'(i) >= rr_q)) begin
            grant_vld = 1'b1;
            grant_idx = LOG2_NUM_PORTS'(i);
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_vld && eligible[i] && (LOG2_NUM_PORTS'(i) < rr_q)) begin
            grant_vld = 1'b1;
            grant_idx = LOG2_NUM_PORTS'(i);
         end
      end
      if (mc_req_stall) begin
         grant_vld = 1'b0;
      end
   end

   always_comb begin
      overflow      = 1'b0;
      unexpected    = 1'b0;
      mc_req_addr_d = mc_req_addr_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         push[i] = req_mem[i] && (cnt_q[i] != FullCnt);
         pop[i]  = grant_vld && (grant_idx == LOG2_NUM_PORTS'(i));
         if (req_mem[i] && (cnt_q[i] == FullCnt)) begin
            overflow = 1'b1;
         end
         if (pop[i]) begin
            mc_req_addr_d = fifo_mem[i][rd_ptr_q[i]];
         end
         cnt_d[i]    = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
         // A response with nothing outstanding is forwarded but must not underflow the count.
         if (rsp_hit[i] && (outst_q[i] == '0) && !issue_hit[i]) begin
            unexpected = 1'b1;
            outst_d[i] = outst_q[i];
         end else begin
            outst_d[i] = outst_q[i] + OutW'(issue_hit[i]) - OutW'(rsp_hit[i]);
         end
      end
      mc_req_ld_d  = grant_vld;
      mc_req_tag_d = grant_vld ? grant_idx : mc_req_tag_q;
      rr_d         = rr_q;
      if (grant_vld) begin
         rr_d = (grant_idx == LastPort) ? '0 : grant_idx + 1'b1;
      end
      rsp_push_d = rsp_hit;
      rsp_data_d = mc_rsp_data;
      err_d      = err_q | {unexpected, bad_tag, overflow};
   end

   always_comb begin
      idle_d = !grant_vld;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if ((cnt_d[i] != '0) || (outst_d[i] != '0)) begin
            idle_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            fifo_mem[i][wr_ptr_q[i]] <= req_mem_addr[48*i +: 48];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         outst_q       <= '0;
         rr_q          <= '0;
         mc_req_ld_q   <= 1'b0;
         mc_req_addr_q <= '0;
         mc_req_tag_q  <= '0;
         rsp_push_q    <= '0;
         rsp_data_q    <= '0;
         err_q         <= '0;
         idle_q        <= 1'b1;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         outst_q       <= outst_d;
         rr_q          <= rr_d;
         mc_req_ld_q   <= mc_req_ld_d;
         mc_req_addr_q <= mc_req_addr_d;
         mc_req_tag_q  <= mc_req_tag_d;
         rsp_push_q    <= rsp_push_d;
         rsp_data_q    <= rsp_data_d;
         err_q         <= err_d;
         idle_q        <= idle_d;
      end
   end

   assign mc_req_ld    = mc_req_ld_q;
   assign mc_req_addr  = mc_req_addr_q;
   assign mc_req_tag   = mc_req_tag_q;
   assign rsp_mem_push = rsp_push_q;
   assign rsp_mem_q    = rsp_data_q;
   assign err_status   = err_q;
   assign idle         = idle_q;

`ifdef ARB_PERF_COUNTERS_EN
   logic [NUM_PORTS-1:0][31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0]                stall_cnt_q, stall_cnt_d;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         issue_cnt_d[i] = issue_cnt_q[i] + 32'(issue_hit[i]);
      end
      stall_cnt_d = stall_cnt_q + 32'(mc_req_stall && (|eligible));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
